shift_reg_seq: RTL and testbench
================================

// Module: shift_reg_seq
// PURPOSE
//   Parametrised universal shift register with a sequenced multi-step shift engine.
//   - Parallel load, or a start/amount command that performs N single-bit steps, one per clock.
//   - Modes: logical shifts, rotates and arithmetic shift right; serial in/out; busy/done handshake.
//   - Datapath utility for serializers and bit-manipulation paths in the same design.
// PARAMETERS
//   WIDTH  8                     register width in bits (>=2)
//   CNT_W  $clog2(WIDTH+1)       width of the amount input and step counter (localparam, derived)
// PORTS
//   clock     in   1      single clock; all state updates on rising edge
//   reset     in   1      asynchronous, active-low reset
//   load      in   1      parallel load strobe
//   data      in   WIDTH  parallel load value
//   sel       in   3      shift mode, sampled with start
//   start     in   1      begin a sequenced shift of `amount` steps
//   amount    in   CNT_W  number of single-bit steps (0..2^CNT_W-1)
//   ser_in    in   1      serial fill bit for SHL/SHR, sampled every step
//   shiftreg  out  WIDTH  register contents
//   ser_out   out  1      bit shifted out by the most recent step
//   busy      out  1      sequence in progress
//   done      out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset (reset=0, async): shiftreg=0, ser_out=0, busy=0, done=0, counter=0, state IDLE.
//   sel encoding (held in shared package):
//     000 HOLD; 001 SHL (ser_in->bit0); 010 SHR (ser_in->MSB); 011 ROL; 100 ROR;
//     101 ASR (MSB replicated); 110/111 reserved, treated as HOLD.
//   FSM states: IDLE, SHIFT. done is a registered pulse, not a state.
//   Priority, highest first: reset > load > SHIFT step > start.
//   IDLE:
//     - load=1: shiftreg<=data; start ignored that cycle.
//     - start=1, amount=0: no shift; done=1 for the following cycle; busy stays 0.
//     - start=1, amount=N>0: latch sel and N; state->SHIFT; busy=1 from the next cycle.
//   SHIFT:
//     - Each edge performs one step in the latched mode and decrements the counter.
//     - ser_out <= bit leaving the register: old MSB for SHL/ROL, old bit0 for SHR/ROR/ASR.
//     - HOLD/reserved modes still count down with shiftreg unchanged; ser_out unchanged.
//     - Edge performing step N: state->IDLE; busy=0 and done=1 in the next cycle.
//     - Latency: start accepted at edge 0; steps on edges 1..N; done high in the cycle after edge N.
//   Mid-operation events:
//     - start while busy: ignored; sel/amount/ser_in changes do not affect the latched mode.
//     - load while busy: aborts; shiftreg<=data; state->IDLE; busy=0; no done pulse.
//     - New start accepted in the same cycle done is high (state already IDLE).
//     - amount>WIDTH legal: shifts keep filling; rotates wrap modulo WIDTH.
//     - reset mid-sequence: immediate return to reset values; no done.
//   ser_out holds its value between sequences; load does not change it.
// STRUCTURE
//   shift_reg_pkg: mode localparams (MODE_HOLD..MODE_ASR), FSM state encodings.
//   Sub-module shift_reg_step: combinational one-step next-value function.
//     in: cur[WIDTH], mode, ser_in; out: nxt[WIDTH], out_bit.
//   Top: FSM, counter, latched mode, registered outputs.
// TESTING (WIDTH=8)
//   1 reset=0 mid-run at any time -> shiftreg=00, ser_out=0, busy=0, done=0 with no clock edge.
//   2 load 81; start sel=ROL amount=1 -> shiftreg=03, ser_out=1; busy 1 cycle; done 1 cycle after edge 1.
//   3 load B4; start sel=ASR amount=3 -> F6 after 3 steps, ser_out=1; busy high exactly 3 cycles.
//   4 load 00; start sel=SHL ser_in=1 amount=8 -> FF, ser_out=0; done in 9th cycle after start.
//   5 start sel=SHR amount=5; load data=5A after step 2 -> shiftreg=5A, busy=0, done never pulses.
//   6 start amount=0 -> done next cycle, busy stays 0, shiftreg unchanged;
//     start while busy ignored, amount count unchanged.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the sequenced shift register: shift modes and FSM states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ASR  = 3'b101,
    MODE_RSV6 = 3'b110,
    MODE_RSV7 = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True for modes that actually move bits (HOLD and reserved only count down).
  function automatic logic mode_moves(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_seq_if.sv
// Command/status bundle for shift_reg_seq; master drives commands, slave is the register.
interface shift_reg_seq_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] data;
  logic [2:0]       sel;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic             ser_in;
  logic [WIDTH-1:0] shiftreg;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output load, data, sel, start, amount, ser_in,
    input  shiftreg, ser_out, busy, done
  );

  modport slave (
    input  load, data, sel, start, amount, ser_in,
    output shiftreg, ser_out, busy, done
  );

endinterface

// File: rtl/shift_reg_step.sv
// Combinational single-step shift: next register value and the bit that leaves it.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_t            mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  always_comb begin
    nxt     = cur;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        nxt     = {cur[WIDTH-2:0], ser_in};
        out_bit = cur[WIDTH-1];
      end
      MODE_SHR: begin
        nxt     = {ser_in, cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      MODE_ROL: begin
        nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
        out_bit = cur[WIDTH-1];
      end
      MODE_ROR: begin
        nxt     = {cur[0], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      MODE_ASR: begin
        nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      default: begin
        nxt     = cur;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Universal shift register with a sequenced N-step shift engine and busy/done handshake.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  shift_reg_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_n;
  mode_t            mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             ser_q;
  logic             done_q;
  logic             busy_c;
  logic [WIDTH-1:0] step_nxt;
  logic             step_out;
  logic             last_step;

  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .cur     (shreg),
    .mode    (mode_q),
    .ser_in  (bus.ser_in),
    .nxt     (step_nxt),
    .out_bit (step_out)
  );

  assign last_step = (cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!bus.load && bus.start && (bus.amount != '0)) state_n = SHIFT;
      SHIFT:   if (bus.load || last_step) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Load outranks a pending step and aborts the sequence without a done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      ser_q  <= 1'b0;
      cnt    <= '0;
      mode_q <= MODE_HOLD;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        shreg <= bus.data;
      end else if (state == SHIFT) begin
        shreg <= step_nxt;
        if (mode_moves(mode_q)) ser_q <= step_out;
        cnt <= cnt - CNT_W'(1);
        if (last_step) done_q <= 1'b1;
      end else if (bus.start) begin
        mode_q <= mode_t'(bus.sel);
        cnt    <= bus.amount;
        if (bus.amount == '0) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy_c = (state == SHIFT);
  end

  assign bus.shiftreg = shreg;
  assign bus.ser_out  = ser_q;
  assign bus.busy     = busy_c;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed and randomized checks of shift_reg_seq against an arithmetic reference model.
module tb_shift_reg_seq;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   mref;
  int   sref;

  shift_reg_seq_if #(.WIDTH(8)) bus ();

  shift_reg_seq #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one step computed with integer arithmetic on an 8-bit value.
  task automatic model_step(input int m, input int s);
    int v;
    v = mref;
    case (m)
      1: begin sref = v / 128; mref = (v * 2) % 256 + s;          end
      2: begin sref = v % 2;   mref = v / 2 + s * 128;            end
      3: begin sref = v / 128; mref = (v * 2) % 256 + v / 128;    end
      4: begin sref = v % 2;   mref = v / 2 + (v % 2) * 128;      end
      5: begin sref = v % 2;   mref = v / 2 + ((v >= 128) ? 128 : 0); end
      default: ;
    endcase
  endtask

  // Optional load, then start; returns in the cycle where done should be high.
  task automatic run_seq(input bit do_load, input int ld, input int m, input int amt,
                         input int fixed_sin, input int poke_step);
    if (do_load) begin
      bus.load = 1'b1;
      bus.data = 8'(ld);
      tick();
      bus.load = 1'b0;
      mref = ld;
      chk("load", int'(bus.shiftreg), mref);
      chk("load_ser", int'(bus.ser_out), sref);
    end
    bus.start  = 1'b1;
    bus.sel    = 3'(m);
    bus.amount = 4'(amt);
    tick();
    bus.start  = 1'b0;
    bus.sel    = 3'($urandom_range(0, 7));
    bus.amount = 4'($urandom_range(0, 15));
    for (int k = 1; k <= amt; k++) begin
      int s;
      chk("busy_run", int'(bus.busy), 1);
      chk("done_run", int'(bus.done), 0);
      s = (fixed_sin >= 0) ? fixed_sin : int'($urandom_range(0, 1));
      bus.ser_in = 1'(s);
      if (k == poke_step) begin
        bus.start  = 1'b1;
        bus.sel    = 3'($urandom_range(0, 7));
        bus.amount = 4'($urandom_range(1, 15));
      end
      tick();
      bus.start = 1'b0;
      model_step(m, s);
      chk("step_val", int'(bus.shiftreg), mref);
      chk("step_ser", int'(bus.ser_out), sref);
    end
    chk("end_busy", int'(bus.busy), 0);
    chk("end_done", int'(bus.done), 1);
    chk("end_val", int'(bus.shiftreg), mref);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mref   = 0;
    sref   = 0;
    bus.load = 1'b0; bus.data = '0; bus.sel = '0; bus.start = 1'b0;
    bus.amount = '0; bus.ser_in = 1'b0;
    reset = 1'b0;
    #12;
    chk("rst_val", int'(bus.shiftreg), 0);
    chk("rst_ser", int'(bus.ser_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b1;
    tick();

    // ROL by one of 81
    run_seq(1'b1, 'h81, 3, 1, -1, 0);
    chk("rol_03", int'(bus.shiftreg), 'h03);
    chk("rol_ser", int'(bus.ser_out), 1);
    tick();
    chk("rol_done_drop", int'(bus.done), 0);

    // ASR by three of B4
    run_seq(1'b1, 'hB4, 5, 3, -1, 0);
    chk("asr_f6", int'(bus.shiftreg), 'hF6);
    chk("asr_ser", int'(bus.ser_out), 1);
    tick();

    // SHL eight ones into 00
    run_seq(1'b1, 'h00, 1, 8, 1, 0);
    chk("shl_ff", int'(bus.shiftreg), 'hFF);
    chk("shl_ser", int'(bus.ser_out), 0);
    tick();

    // SHR aborted by load after step 2
    bus.load = 1'b1; bus.data = 8'h3C; tick(); bus.load = 1'b0; mref = 'h3C;
    bus.start = 1'b1; bus.sel = 3'd2; bus.amount = 4'd5; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      bus.ser_in = 1'($urandom_range(0, 1));
      model_step(2, int'(bus.ser_in));
      tick();
      chk("abort_step", int'(bus.shiftreg), mref);
    end
    bus.load = 1'b1; bus.data = 8'h5A; tick(); bus.load = 1'b0; mref = 'h5A;
    chk("abort_val", int'(bus.shiftreg), 'h5A);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ser", int'(bus.ser_out), sref);
    for (int k = 0; k < 6; k++) begin
      chk("abort_nodone", int'(bus.done), 0);
      tick();
    end

    // amount 0: done next cycle, busy never rises, value kept
    run_seq(1'b0, 0, 3, 0, -1, 0);
    // back-to-back start in the done cycle, with a start poked mid-run
    run_seq(1'b0, 0, 1, 4, -1, 2);
    tick();
    chk("b2b_done_drop", int'(bus.done), 0);

    // asynchronous reset mid-sequence, away from any clock edge
    bus.load = 1'b1; bus.data = 8'hA5; tick(); bus.load = 1'b0;
    bus.start = 1'b1; bus.sel = 3'd4; bus.amount = 4'd6; tick(); bus.start = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_val", int'(bus.shiftreg), 0);
    chk("mid_rst_ser", int'(bus.ser_out), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    #2 reset = 1'b1;
    mref = 0; sref = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_done", int'(bus.done), 0);
    end

    // randomized sequences, including reserved modes and amounts beyond WIDTH
    for (int r = 0; r < 30; r++) begin
      bit dl;
      dl = ($urandom_range(0, 2) != 0);
      run_seq(dl, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), -1, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
